// File: rtl/qam_frame_sequencer.sv
// Frame sequencer ahead of the 16-QAM mapper: header injection, payload forwarding,
// return snooping and mapper reset pulse. Optional DRAIN watchdog: define QAM_SEQ_TIMEOUT_EN.
module qam_frame_sequencer #(
    parameter int          DATA_WIDTH = 64,
    parameter int          LEN_WIDTH  = 16,
    parameter logic [15:0] HDR_TAG    = 16'hFFFF,
    parameter int          RST_CYCLES = 4
`ifdef QAM_SEQ_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset,
    input  logic                  cfg_start,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [47:0]           cfg_hdr_lo,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic                  stat_last_mismatch,
`ifdef QAM_SEQ_TIMEOUT_EN
    output logic                  stat_timeout,
`endif
    input  logic                  s_axis_valid,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_last,
    output logic                  s_axis_ready,
    output logic                  m_axis_valid,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_last,
    input  logic                  m_axis_ready,
    input  logic                  r_axis_valid,
    input  logic                  r_axis_ready,
    output logic                  qam_rst_n
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HDR   = 3'd1;
    localparam logic [2:0] PAY   = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] FLUSH = 3'd4;

    localparam int FW = $clog2(RST_CYCLES + 1);

    logic [2:0]           state;
    logic [LEN_WIDTH-1:0] len_q;
    logic [47:0]          hdr_lo_q;
    logic [LEN_WIDTH-1:0] pay_cnt;
    logic [LEN_WIDTH:0]   ret_cnt;
    logic [FW-1:0]        flush_cnt;
    logic                 last_word;
    logic                 s_fire;
    logic                 r_fire;
    logic                 ret_done;

`ifdef QAM_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
`endif

    assign last_word = (pay_cnt == len_q - LEN_WIDTH'(1));
    assign s_fire    = s_axis_valid & s_axis_ready;
    assign r_fire    = r_axis_valid & r_axis_ready;
    assign ret_done  = (ret_cnt == {1'b0, len_q} + (LEN_WIDTH + 1)'(1));
    assign busy      = (state != IDLE);
    assign qam_rst_n = ~(axi_reset | (state == FLUSH));

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        s_axis_ready = 1'b0;
        m_axis_valid = 1'b0;
        m_axis_last  = 1'b0;
        m_axis_data  = DATA_WIDTH'({HDR_TAG, hdr_lo_q});
        case (state)
            HDR: m_axis_valid = 1'b1;
            PAY: begin
                m_axis_valid = s_axis_valid;
                s_axis_ready = m_axis_ready;
                m_axis_data  = s_axis_data;
                m_axis_last  = last_word;
            end
            default: ;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state              <= IDLE;
            len_q              <= '0;
            hdr_lo_q           <= '0;
            pay_cnt            <= '0;
            ret_cnt            <= '0;
            flush_cnt          <= '0;
            done               <= 1'b0;
            cfg_err            <= 1'b0;
            stat_last_mismatch <= 1'b0;
`ifdef QAM_SEQ_TIMEOUT_EN
            to_cnt             <= '0;
            stat_timeout       <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;

            // Returns can overlap PAY, so they are counted from header entry onward.
            if ((state == HDR || state == PAY || state == DRAIN) && r_fire)
                ret_cnt <= ret_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        if (cfg_len != '0) begin
                            len_q              <= cfg_len;
                            hdr_lo_q           <= cfg_hdr_lo;
                            pay_cnt            <= '0;
                            ret_cnt            <= '0;
                            flush_cnt          <= '0;
                            stat_last_mismatch <= 1'b0;
`ifdef QAM_SEQ_TIMEOUT_EN
                            to_cnt             <= '0;
                            stat_timeout       <= 1'b0;
`endif
                            state              <= HDR;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                HDR: begin
                    if (m_axis_ready)
                        state <= PAY;
                end
                PAY: begin
                    if (s_fire) begin
                        pay_cnt <= pay_cnt + 1'b1;
                        if (s_axis_last != last_word)
                            stat_last_mismatch <= 1'b1;
                        if (last_word)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (ret_done) begin
                        state     <= FLUSH;
                        flush_cnt <= FW'(RST_CYCLES);
                    end
`ifdef QAM_SEQ_TIMEOUT_EN
                    else if (r_fire) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        stat_timeout <= 1'b1;
                        state        <= FLUSH;
                        flush_cnt    <= FW'(RST_CYCLES);
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt - 1'b1;
                    if (flush_cnt == FW'(1)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qam_frame_sequencer.sv
// Randomized bench for qam_frame_sequencer: a transaction-level model predicts the mapper
// word stream and frame status; a 2-cycle mirror stands in for the mapper return path.
module tb_qam_frame_sequencer;

    logic        axi_clk = 1'b0;
    logic        axi_reset;
    logic        cfg_start;
    logic [15:0] cfg_len;
    logic [47:0] cfg_hdr_lo;
    logic        busy, done, cfg_err, stat_last_mismatch;
`ifdef QAM_SEQ_TIMEOUT_EN
    logic        stat_timeout;
`endif
    logic        s_axis_valid, s_axis_last, s_axis_ready;
    logic [63:0] s_axis_data;
    logic        m_axis_valid, m_axis_last, m_axis_ready;
    logic [63:0] m_axis_data;
    logic        r_axis_valid, r_axis_ready;
    logic        qam_rst_n;

    always #5 axi_clk = ~axi_clk;

    qam_frame_sequencer #(
        .DATA_WIDTH(64),
        .LEN_WIDTH(16)
`ifdef QAM_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .axi_clk(axi_clk), .axi_reset(axi_reset),
        .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_hdr_lo(cfg_hdr_lo),
        .busy(busy), .done(done), .cfg_err(cfg_err), .stat_last_mismatch(stat_last_mismatch),
`ifdef QAM_SEQ_TIMEOUT_EN
        .stat_timeout(stat_timeout),
`endif
        .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data), .s_axis_last(s_axis_last),
        .s_axis_ready(s_axis_ready),
        .m_axis_valid(m_axis_valid), .m_axis_data(m_axis_data), .m_axis_last(m_axis_last),
        .m_axis_ready(m_axis_ready),
        .r_axis_valid(r_axis_valid), .r_axis_ready(r_axis_ready),
        .qam_rst_n(qam_rst_n)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [63:0] src_q[$];
    logic        src_last[$];
    logic [64:0] out_q[$];
    int          src_idx, s_fire_cnt, rst_low_cnt, done_cnt, cfg_err_cnt;
    int          r_issued, r_limit, mready_mode;
    logic [1:0]  r_pipe;
    logic        prev_stall, busy_at_done;
    logic [63:0] prev_data;

    // One clock: observe at the falling edge, drive just after the rising edge.
    task automatic step();
        bit fired;
        @(negedge axi_clk);
        if (m_axis_valid && m_axis_ready) out_q.push_back({m_axis_last, m_axis_data});
        fired = s_axis_valid && s_axis_ready;
        if (fired) begin
            s_fire_cnt++;
            src_idx++;
        end
        if (prev_stall) begin
            check("stall_valid", 64'(m_axis_valid), 64'd1);
            check("stall_data", m_axis_data, prev_data);
        end
        prev_stall = m_axis_valid && !m_axis_ready;
        prev_data  = m_axis_data;
        if (!qam_rst_n) rst_low_cnt++;
        if (done) begin
            done_cnt++;
            busy_at_done = busy;
        end
        if (cfg_err) cfg_err_cnt++;
        r_pipe = {r_pipe[0], m_axis_valid && m_axis_ready};
        @(posedge axi_clk);
        #1;
        if (src_idx < src_q.size()) begin
            if (!s_axis_valid || fired) s_axis_valid = ($urandom_range(0, 3) != 0);
            s_axis_data = src_q[src_idx];
            s_axis_last = src_last[src_idx];
        end else begin
            s_axis_valid = 1'b0;
        end
        case (mready_mode)
            0:       m_axis_ready = 1'b1;
            1:       m_axis_ready = ~m_axis_ready;
            default: m_axis_ready = 1'($urandom_range(0, 1));
        endcase
        r_axis_valid = r_pipe[1] && (r_issued < r_limit);
        if (r_axis_valid) r_issued++;
    endtask

    task automatic start_frame(input int len, input logic [47:0] hdr, input int mode,
                               input int last_idx, input int rlim);
        src_q.delete();
        src_last.delete();
        for (int i = 0; i < len; i++) begin
            src_q.push_back({$urandom, $urandom});
            src_last.push_back(i == last_idx);
        end
        out_q.delete();
        src_idx = 0; s_fire_cnt = 0; rst_low_cnt = 0; done_cnt = 0; cfg_err_cnt = 0;
        r_issued = 0; r_limit = rlim; r_pipe = 2'b00; prev_stall = 1'b0; busy_at_done = 1'b1;
        mready_mode = mode;
        s_axis_valid = 1'b0;
        cfg_len = 16'(len);
        cfg_hdr_lo = hdr;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic run_frame(input int len, input logic [47:0] hdr, input int mode,
                             input int last_idx, input bit mid_start, input int rlim);
        int cycles;
        logic [64:0] exp_word;
        start_frame(len, hdr, mode, last_idx, rlim);
        cycles = 0;
        while (done_cnt == 0 && cycles < 3000) begin
            if (mid_start && cycles == 3) begin
                cfg_start = 1'b1;
                cfg_len   = 16'd0;
            end else begin
                cfg_start = 1'b0;
            end
            step();
            cycles++;
        end
        cfg_start = 1'b0;
        check("done_seen", 64'(done_cnt > 0), 64'd1);
        check("busy_at_done", 64'(busy_at_done), 64'd0);
        step();
        step();
        check("done_once", 64'(done_cnt), 64'd1);
        check("no_cfg_err", 64'(cfg_err_cnt), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        check("out_count", 64'(out_q.size()), 64'(len + 1));
        for (int i = 0; i < out_q.size() && i <= len; i++) begin
            if (i == 0) exp_word = {1'b0, 16'hFFFF, hdr};
            else        exp_word = {1'(i == len), src_q[i-1]};
            check($sformatf("word%0d", i), 64'(out_q[i][63:0]), exp_word[63:0]);
            check($sformatf("last%0d", i), 64'(out_q[i][64]), 64'(exp_word[64]));
        end
        check("s_handshakes", 64'(s_fire_cnt), 64'(len));
        check("qam_rst_low", 64'(rst_low_cnt), 64'd4);
        check("last_mismatch", 64'(stat_last_mismatch), 64'(last_idx != len - 1));
`ifdef QAM_SEQ_TIMEOUT_EN
        check("stat_timeout", 64'(stat_timeout), 64'(rlim < len + 1));
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_cfg_err"}, 64'(cfg_err), 64'd0);
        check({tag, "_mm"}, 64'(stat_last_mismatch), 64'd0);
        check({tag, "_m_valid"}, 64'(m_axis_valid), 64'd0);
        check({tag, "_m_last"}, 64'(m_axis_last), 64'd0);
        check({tag, "_s_ready"}, 64'(s_axis_ready), 64'd0);
        check({tag, "_qam_rst_n"}, 64'(qam_rst_n), 64'd0);
    endtask

    initial begin
        int guard;
        int len;
        axi_reset = 1'b1; cfg_start = 1'b0; cfg_len = '0; cfg_hdr_lo = '0;
        s_axis_valid = 1'b0; s_axis_data = '0; s_axis_last = 1'b0;
        m_axis_ready = 1'b0; r_axis_valid = 1'b0; r_axis_ready = 1'b1;
        r_pipe = 2'b00; r_limit = 1000; r_issued = 0; mready_mode = 0;
        src_idx = 0; prev_stall = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        axi_reset = 1'b0;
        step();
        check("qam_rst_n_released", 64'(qam_rst_n), 64'd1);

        // Basic frame, then full-rate backpressure toggling.
        run_frame(3, 48'h0000_0000_00A5, 0, 2, 1'b0, 1000);
        run_frame(4, {$urandom, 16'($urandom)}, 1, 3, 1'b0, 1000);

        // Zero-length start is rejected.
        cfg_len = 16'd0;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        check("cfg_err_pulse", 64'(cfg_err), 64'd1);
        check("cfg_err_busy", 64'(busy), 64'd0);
        step();
        check("cfg_err_clear", 64'(cfg_err), 64'd0);
        check("cfg_err_still_idle", 64'(busy), 64'd0);

        // Start while busy is ignored; upstream last on the wrong word is flagged.
        run_frame(3, {$urandom, 16'($urandom)}, 2, 2, 1'b1, 1000);
        run_frame(2, {$urandom, 16'($urandom)}, 0, 0, 1'b0, 1000);
        run_frame(2, {$urandom, 16'($urandom)}, 0, 1, 1'b0, 1000);

        // Reset during payload after the first word.
        start_frame(5, 48'h1234_5678_9ABC, 0, 4, 1000);
        guard = 0;
        while (s_fire_cnt < 1 && guard < 200) begin
            step();
            guard++;
        end
        check("reset_mid_pay_reached", 64'(s_fire_cnt), 64'd1);
        axi_reset = 1'b1;
        #1;
        check("qam_rst_n_during_reset", 64'(qam_rst_n), 64'd0);
        step();
        check_reset_outputs("mid_reset");
        axi_reset = 1'b0;
        src_q.delete();
        s_axis_valid = 1'b0;
        step();
        run_frame(1, {$urandom, 16'($urandom)}, 0, 0, 1'b0, 1000);

        for (int n = 0; n < 6; n++) begin
            len = $urandom_range(1, 10);
            run_frame(len, {$urandom, 16'($urandom)}, $urandom_range(0, 2), len - 1, 1'b0, 1000);
        end

`ifdef QAM_SEQ_TIMEOUT_EN
        run_frame(2, {$urandom, 16'($urandom)}, 0, 1, 1'b0, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
